// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch
// requester and the load/store requester. Each access runs
// IDLE -> ACCESS -> [WAIT] -> DONE and is never pre-empted.
// All outputs are registered.
// Build option: define MEM_ARB_RR_EN to replace the fixed data-over-fetch
// priority with round-robin arbitration.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1    // legal 1..15
) (
    input  logic              iClk,
    input  logic              iRst_n,
    // instruction fetch requester
    input  logic              iFetchReq,
    input  logic [ADDR_W-1:0] iFetchAddr,
    output logic              oFetchGnt,
    output logic              oFetchValid,
    output logic [DATA_W-1:0] oFetchData,
    // load/store requester
    input  logic              iDataReq,
    input  logic              iDataWe,
    input  logic [ADDR_W-1:0] iDataAddr,
    input  logic [DATA_W-1:0] iDataWdata,
    output logic              oDataGnt,
    output logic              oDataValid,
    output logic [DATA_W-1:0] oDataRdata,
    // RAM side
    output logic [ADDR_W-1:0] oRamAddress,
    output logic              oRamEnable,
    output logic              oRamRW,
    output logic [DATA_W-1:0] oRamData,
    input  logic [DATA_W-1:0] iRamData,
    // status
    output logic              oBusy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StDone
    } state_e;

    // The counter is loaded on leaving ACCESS and reaches 0 in the last WAIT cycle.
    localparam logic [3:0] WaitInit = 4'(RD_LAT - 1);

    state_e              state_q;
    logic                sel_data_q;    // winner of the current transaction: 1 = data
    logic [3:0]          wait_cnt_q;

    logic                fetch_gnt_q;
    logic                fetch_valid_q;
    logic [DATA_W-1:0]   fetch_data_q;
    logic                data_gnt_q;
    logic                data_valid_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_en_q;
    logic                ram_rw_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic                busy_q;

    logic                any_req;
    logic                pick_data;

`ifdef MEM_ARB_RR_EN
    logic                last_data_q;   // last served: 0 = fetch, 1 = data
`endif

    // Arbitration decision, only consumed in IDLE.
    always_comb begin
        any_req = iFetchReq | iDataReq;
`ifdef MEM_ARB_RR_EN
        // On a tie the requester that was not served last wins.
        pick_data = iDataReq & (~iFetchReq | ~last_data_q);
`else
        pick_data = iDataReq;
`endif
    end

    // Access sequencer: state, wait counter and every registered output.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q       <= StIdle;
            sel_data_q    <= 1'b0;
            wait_cnt_q    <= 4'd0;
            fetch_gnt_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            data_gnt_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            data_rdata_q  <= '0;
            ram_addr_q    <= '0;
            ram_en_q      <= 1'b0;
            ram_rw_q      <= 1'b0;
            ram_data_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            // Grants, strobe and valids are single-cycle pulses.
            fetch_gnt_q   <= 1'b0;
            data_gnt_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q    <= StAccess;
                        sel_data_q <= pick_data;
                        busy_q     <= 1'b1;
                        if (pick_data) begin
                            ram_addr_q <= iDataAddr;
                            ram_rw_q   <= iDataWe;
                            ram_data_q <= iDataWdata;
                            ram_en_q   <= iDataWe;
                            data_gnt_q <= 1'b1;
                        end else begin
                            // Fetches are always reads; write data is left as is.
                            ram_addr_q  <= iFetchAddr;
                            ram_rw_q    <= 1'b0;
                            fetch_gnt_q <= 1'b1;
                        end
                    end
                end

                StAccess: begin
                    if (ram_rw_q) begin
                        // Store is complete once the strobe has been presented.
                        state_q      <= StDone;
                        data_valid_q <= sel_data_q;
                        fetch_valid_q <= ~sel_data_q;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= WaitInit;
                    end
                end

                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= StDone;
                        if (sel_data_q) begin
                            data_rdata_q <= iRamData;
                            data_valid_q <= 1'b1;
                        end else begin
                            fetch_data_q  <= iRamData;
                            fetch_valid_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last-served tracker, updated when a winner is chosen.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            last_data_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            last_data_q <= pick_data;
        end
    end
`endif

    assign oFetchGnt   = fetch_gnt_q;
    assign oFetchValid = fetch_valid_q;
    assign oFetchData  = fetch_data_q;
    assign oDataGnt    = data_gnt_q;
    assign oDataValid  = data_valid_q;
    assign oDataRdata  = data_rdata_q;
    assign oRamAddress = ram_addr_q;
    assign oRamEnable  = ram_en_q;
    assign oRamRW      = ram_rw_q;
    assign oRamData    = ram_data_q;
    assign oBusy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM plus a transaction-level
// reference model (arbitration rule, latency arithmetic, shadow memory).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req, fetch_gnt, fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              data_req, data_we, data_gnt, data_valid;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en, ram_rw, busy;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iFetchReq  (fetch_req),
        .iFetchAddr (fetch_addr),
        .oFetchGnt  (fetch_gnt),
        .oFetchValid(fetch_valid),
        .oFetchData (fetch_data),
        .iDataReq   (data_req),
        .iDataWe    (data_we),
        .iDataAddr  (data_addr),
        .iDataWdata (data_wdata),
        .oDataGnt   (data_gnt),
        .oDataValid (data_valid),
        .oDataRdata (data_rdata),
        .oRamAddress(ram_addr),
        .oRamEnable (ram_en),
        .oRamRW     (ram_rw),
        .oRamData   (ram_wdata),
        .iRamData   (ram_rdata),
        .oBusy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural RAM ----------------
    function automatic logic [31:0] init_word(input logic [11:0] a);
        if (a == 12'h010) return 32'h0000_ABCD;
        return {4'hA, a, 4'h5, ~a};
    endfunction

    logic [31:0] mem [4096];
    bit          written [4096];
    logic [31:0] rd_pipe [RD_LAT];

    function automatic logic [31:0] ram_word(input logic [11:0] a);
        return written[a] ? mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= ram_word(ram_addr);
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        if (ram_en && ram_rw) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [4096];
    bit          model_last_data;   // last served: 0 = fetch
    logic [31:0] exp_fetch_data;
    logic [31:0] exp_load_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {busy, fetch_gnt, data_gnt, fetch_valid, data_valid,
                                  ram_en, ram_rw, ram_addr}, '0);
        check_eq({tag, "_wdat"}, ram_wdata, '0);
        check_eq({tag, "_fdat"}, fetch_data, '0);
        check_eq({tag, "_ddat"}, data_rdata, '0);
    endtask

    // One arbitration round: fetch and/or data raised together while idle.
    task automatic run_txn(input bit f_on, input bit d_on, input bit we,
                           input logic [11:0] fa, input logic [11:0] da,
                           input logic [31:0] wd, input bit drop_early);
        int          exp_g[2], exp_v[2], obs_g[2], obs_v[2], nval[2];
        logic [31:0] exp_d[2], obs_d[2];
        bit          on[2], order[2];
        int          ntx, start, lat, c, t, en_cnt, busy_cnt, exp_busy, exp_en;
        bit          pending;

        on[0] = f_on;
        on[1] = d_on;
        if (f_on && d_on) order[0] = RrEn ? (model_last_data == 1'b0) : 1'b1;
        else              order[0] = d_on;
        order[1] = ~order[0];
        ntx = int'(f_on) + int'(d_on);

        @(negedge clk);
        start = cyc;
        fetch_req = f_on; fetch_addr = fa;
        data_req = d_on; data_we = we; data_addr = da; data_wdata = wd;

        // Predict timing and data for each transaction in service order.
        exp_busy = 0;
        exp_en   = 0;
        for (int k = 0; k < ntx; k++) begin
            int s;
            s   = int'(order[k]);
            lat = (s == 1 && we) ? 0 : int'(RD_LAT);
            exp_g[s] = start + 1;
            exp_v[s] = start + 2 + lat;
            exp_busy += exp_v[s] - start;
            start = exp_v[s] + 1;
            if (s == 0) begin
                exp_d[0] = ref_mem[fa];
                exp_fetch_data = exp_d[0];
            end else if (we) begin
                ref_mem[da] = wd;
                exp_en++;
                exp_d[1] = exp_load_data;
            end else begin
                exp_d[1] = ref_mem[da];
                exp_load_data = exp_d[1];
            end
            model_last_data = order[k];
        end

        for (int s = 0; s < 2; s++) begin
            obs_g[s] = -1; obs_v[s] = -1; nval[s] = 0; obs_d[s] = '0;
        end
        en_cnt = 0; busy_cnt = 0; t = 0;
        pending = 1'b1;
        while (pending && t < 80) begin
            @(negedge clk);
            t++;
            c = cyc;
            if (fetch_gnt) begin
                obs_g[0] = c;
                check_eq("f_ram_addr", ram_addr, fa);
                check_eq("f_ram_rw", ram_rw, 0);
                if (drop_early) fetch_req = 1'b0;
            end
            if (data_gnt) begin
                obs_g[1] = c;
                check_eq("d_ram_addr", ram_addr, da);
                check_eq("d_ram_rw", ram_rw, we);
                if (we) check_eq("d_ram_wdata", ram_wdata, wd);
                if (drop_early) data_req = 1'b0;
            end
            if (ram_en) en_cnt++;
            if (busy) busy_cnt++;
            if (fetch_valid) begin
                obs_v[0] = c; nval[0]++; obs_d[0] = fetch_data; fetch_req = 1'b0;
            end
            if (data_valid) begin
                obs_v[1] = c; nval[1]++; obs_d[1] = data_rdata; data_req = 1'b0;
            end
            pending = (on[0] && obs_v[0] < 0) || (on[1] && obs_v[1] < 0);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        check_eq("txn_done", !pending, 1);

        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("extra_valid", {fetch_valid, data_valid}, 0);

        for (int s = 0; s < 2; s++) begin
            if (on[s]) begin
                check_eq(s ? "d_gnt_cyc" : "f_gnt_cyc", obs_g[s], exp_g[s]);
                check_eq(s ? "d_vld_cyc" : "f_vld_cyc", obs_v[s], exp_v[s]);
                check_eq(s ? "d_data" : "f_data", obs_d[s], exp_d[s]);
                check_eq(s ? "d_vld_cnt" : "f_vld_cnt", nval[s], 1);
            end else begin
                check_eq(s ? "d_spur_gnt" : "f_spur_gnt", obs_g[s], -1);
                check_eq(s ? "d_spur_vld" : "f_spur_vld", nval[s], 0);
            end
        end
        check_eq("ram_en_cnt", en_cnt, exp_en);
        check_eq("busy_cnt", busy_cnt, exp_busy);
        check_eq("fetch_reg", fetch_data, exp_fetch_data);
        check_eq("load_reg", data_rdata, exp_load_data);
    endtask

    // Both requesters hold their request for four completions (loads only).
    task automatic run_hold4();
        bit exp_seq[4];
        bit last;
        int nv, t;
        last = model_last_data;
        for (int k = 0; k < 4; k++) begin
            exp_seq[k] = RrEn ? ~last : 1'b1;
            last = exp_seq[k];
        end
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 12'($urandom_range(0, 31));
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'($urandom_range(0, 31));
        nv = 0; t = 0;
        while (nv < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if ((data_valid || fetch_valid) && nv < 4) begin
                check_eq("hold_who", data_valid, exp_seq[nv]);
                if (data_valid) begin
                    check_eq("hold_ddata", data_rdata, ref_mem[data_addr]);
                    exp_load_data = ref_mem[data_addr];
                    data_addr = 12'($urandom_range(0, 31));
                end else begin
                    check_eq("hold_fdata", fetch_data, ref_mem[fetch_addr]);
                    exp_fetch_data = ref_mem[fetch_addr];
                    fetch_addr = 12'($urandom_range(0, 31));
                end
                model_last_data = exp_seq[nv];
                nv++;
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        check_eq("hold_cnt", nv, 4);
        @(negedge clk);
        check_eq("hold_idle", busy, 0);
    endtask

    // Reset asserted in WAIT of a load: transaction abandoned, then reissued.
    task automatic run_reset_mid();
        int nv;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'h005;
        repeat (2) @(negedge clk);
        check_eq("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (fetch_valid || data_valid) nv++;
        end
        check_eq("rst_no_vld", nv, 0);
        model_last_data = 1'b0;
        exp_fetch_data  = '0;
        exp_load_data   = '0;
        run_txn(1'b0, 1'b1, 1'b0, 12'h0, 12'h005, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(12'(i));
        model_last_data = 1'b0;
        exp_fetch_data = '0;
        exp_load_data = '0;
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_txn(1'b0, 1'b1, 1'b0, 12'h000, 12'h010, 32'h0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 32'h1234_5678, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 12'h020, 12'h000, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 32'h0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 32'h0, 1'b1);
        run_txn(1'b1, 1'b1, 1'b1, 12'h030, 12'h030, 32'hCAFE_F00D, 1'b1);
        run_hold4();
        run_reset_mid();

        // Randomised rounds.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [11:0] fa, da;
            r  = int'($urandom_range(1, 3));
            fa = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
            da = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
            run_txn(r[0], r[1], 1'($urandom_range(0, 1)), fa, da, $urandom,
                    ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
